ppfifo_read_arbiter: RTL

Round-robin arbiter that shares one downstream ping-pong FIFO read port among `NUM_CH` upstream ping-pong FIFO read interfaces. It sits between several producer FIFOs and a single PPFIFO-to-AXI-Stream converter. The arbiter grants one complete FIFO block at a time. It muxes the granted channel's data and size onto the shared port and routes read strobes back to the granted channel only. It also reports the granted channel and flags over-reads.

---
 rtl/ppfifo_read_arbiter_if.sv | 30 +++
 rtl/ppfifo_read_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ppfifo_read_arbiter_if.sv
// Shared-port bundle for the ping-pong FIFO read arbiter: upstream channel buses and the
// single downstream port. The arbiter uses the slave modport; the environment uses master.
interface ppfifo_read_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0]    i_up_rdy;
  logic [NUM_CH-1:0]    o_up_act;
  logic [NUM_CH*24-1:0] i_up_size;
  logic [NUM_CH*32-1:0] i_up_data;
  logic [NUM_CH-1:0]    o_up_stb;
  logic                 o_dn_rdy;
  logic                 i_dn_act;
  logic [23:0]          o_dn_size;
  logic [31:0]          o_dn_data;
  logic                 i_dn_stb;
  logic [CH_W-1:0]      o_channel;
  logic                 o_busy;
  logic                 o_overrun;

  modport master (
    output i_up_rdy, i_up_size, i_up_data, i_dn_act, i_dn_stb,
    input  o_up_act, o_up_stb, o_dn_rdy, o_dn_size, o_dn_data, o_channel, o_busy, o_overrun
  );

  modport slave (
    input  i_up_rdy, i_up_size, i_up_data, i_dn_act, i_dn_stb,
    output o_up_act, o_up_stb, o_dn_rdy, o_dn_size, o_dn_data, o_channel, o_busy, o_overrun
  );
endinterface

// File: rtl/ppfifo_read_arbiter.sv
// Round-robin arbiter granting one whole ping-pong FIFO block at a time from NUM_CH
// upstream channels onto a single downstream read port.
//
// state      | meaning
// IDLE       | no grant; arbitrate when a channel is ready and downstream is not active
// ACTIVATE   | grant asserted; one cycle for the upstream FIFO to present size/data
// OFFER      | block offered downstream (o_dn_rdy high) until the consumer activates
// BUSY       | consumer reading; ends when i_dn_act drops
// RELEASE    | grant dropped; one cycle for the upstream FIFO to swap banks
module ppfifo_read_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ppfifo_read_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACTIVATE = 3'd1,
    S_OFFER    = 3'd2,
    S_BUSY     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_last;
  logic [CH_W-1:0]   r_channel;
  logic [NUM_CH-1:0] r_up_act;
  logic              r_dn_rdy;
  logic              r_overrun;
  logic [23:0]       r_count;

  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_found;
  logic [23:0]       w_size;
  logic [31:0]       w_data;
  logic              w_in_xfer;
  logic              w_stb_ok;
  logic              w_route;
  logic              w_drop;

  // First ready channel searching upward from the one after the last grant.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_last) + i) % NUM_CH);
      if (!w_found && bus.i_up_rdy[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_size = '0;
    w_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_channel == CH_W'(k)) begin
        w_size = bus.i_up_size[k*24 +: 24];
        w_data = bus.i_up_data[k*32 +: 32];
      end
    end
  end

  // Strobes during reset are discarded so no word is lost mid-block.
  assign w_in_xfer = (r_state == S_OFFER) || (r_state == S_BUSY);
  assign w_stb_ok  = bus.i_dn_stb && bus.i_dn_act && w_in_xfer && !rst;
  assign w_route   = w_stb_ok && (r_count < w_size);
  assign w_drop    = w_stb_ok && !(r_count < w_size);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= CH_W'(NUM_CH - 1);
      r_channel <= '0;
      r_up_act  <= '0;
      r_dn_rdy  <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_route) r_count <= r_count + 24'd1;
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_found && !bus.i_dn_act) begin
            r_channel <= w_grant;
            r_up_act  <= NUM_CH'(1) << w_grant;
            r_state   <= S_ACTIVATE;
          end
        end
        S_ACTIVATE: begin
          r_count  <= '0;
          r_dn_rdy <= 1'b1;
          r_state  <= S_OFFER;
        end
        S_OFFER: begin
          if (bus.i_dn_act) begin
            r_dn_rdy <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!bus.i_dn_act) begin
            r_up_act <= '0;
            r_last   <= r_channel;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_up_act  = r_up_act;
  assign bus.o_up_stb  = w_route ? (NUM_CH'(1) << r_channel) : '0;
  assign bus.o_dn_rdy  = r_dn_rdy;
  assign bus.o_dn_size = (r_state == S_IDLE) ? 24'd0 : w_size;
  assign bus.o_dn_data = w_data;
  assign bus.o_channel = r_channel;
  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_overrun = r_overrun;

endmodule
